// File: rtl/float_argmax_stream.sv
// Streaming IEEE-754 single-precision argmax/argmin reduction.
// Takes one element per cycle and holds {value, index, flags} until the consumer accepts it.
module float_argmax_stream #(
  parameter bit          FIND_MIN    = 1'b0,
  parameter int unsigned INDEX_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [31:0]            in_data_i,
  input  logic                   in_valid_i,
  input  logic                   in_last_i,
  output logic                   in_ready_o,
  output logic [31:0]            out_value_o,
  output logic [INDEX_WIDTH-1:0] out_index_o,
  output logic                   out_found_o,
  output logic                   out_nan_o,
  output logic                   out_ovf_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i
);

  localparam logic [INDEX_WIDTH-1:0] IdxMax   = '1;
  localparam logic [31:0]            QuietNan = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            cand_q, cand_d;
  logic [INDEX_WIDTH-1:0] cand_idx_q, cand_idx_d;
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic                   cnt_full_q, cnt_full_d;
  logic                   found_q, found_d;
  logic                   nan_q, nan_d;
  logic                   ovf_q, ovf_d;

  logic        accept;
  logic        in_is_nan;
  logic [31:0] in_key;
  logic [31:0] cand_key;
  logic        in_better;
  logic        take;

  // Maps float bits onto an unsigned key with the same total order (-0 < +0).
  function automatic logic [31:0] order_key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  assign in_is_nan = (in_data_i[30:23] == 8'hFF) && (in_data_i[22:0] != 23'd0);
  assign in_key    = order_key(in_data_i);
  assign cand_key  = order_key(cand_q);
  assign in_better = FIND_MIN ? (in_key < cand_key) : (in_key > cand_key);
  assign take      = !in_is_nan && (!found_q || in_better);
  assign accept    = in_valid_i && (state_q != StDone);

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cand_idx_d = cand_idx_q;
    cnt_d      = cnt_q;
    cnt_full_d = cnt_full_q;
    found_d    = found_q;
    nan_d      = nan_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
          state_d = in_last_i ? StDone : StAccum;
          if (take) begin
            cand_d     = in_data_i;
            cand_idx_d = cnt_q;
            found_d    = 1'b1;
          end
          if (in_is_nan) nan_d = 1'b1;
          // cnt_full marks that index IdxMax has already been consumed by an earlier beat.
          if (cnt_full_q) ovf_d = 1'b1;
          if (cnt_q == IdxMax) begin
            cnt_full_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d    = StIdle;
          cand_d     = 32'd0;
          cand_idx_d = '0;
          cnt_d      = '0;
          cnt_full_d = 1'b0;
          found_d    = 1'b0;
          nan_d      = 1'b0;
          ovf_d      = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      cand_q     <= 32'd0;
      cand_idx_q <= '0;
      cnt_q      <= '0;
      cnt_full_q <= 1'b0;
      found_q    <= 1'b0;
      nan_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cand_idx_q <= cand_idx_d;
      cnt_q      <= cnt_d;
      cnt_full_q <= cnt_full_d;
      found_q    <= found_d;
      nan_q      <= nan_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    in_ready_o  = (state_q != StDone);
    out_valid_o = (state_q == StDone);
    out_index_o = cand_idx_q;
    out_found_o = found_q;
    out_nan_o   = nan_q;
    out_ovf_o   = ovf_q;
    // An all-NaN vector reports a canonical quiet NaN.
    if (found_q) begin
      out_value_o = cand_q;
    end else if (state_q == StDone) begin
      out_value_o = QuietNan;
    end else begin
      out_value_o = 32'd0;
    end
  end

endmodule

// File: tb/tb_float_argmax_stream.sv
// Directed bench: three instances (max, min, 2-bit index) share one input stream.
module tb_float_argmax_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;

  logic        mx_in_ready, mx_found, mx_nan, mx_ovf, mx_valid;
  logic [31:0] mx_value;
  logic [15:0] mx_index;
  logic        mn_in_ready, mn_found, mn_nan, mn_ovf, mn_valid;
  logic [31:0] mn_value;
  logic [15:0] mn_index;
  logic        ov_in_ready, ov_found, ov_nan, ov_ovf, ov_valid;
  logic [31:0] ov_value;
  logic [1:0]  ov_index;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  float_argmax_stream #(.FIND_MIN(1'b0), .INDEX_WIDTH(16)) u_max (
    .clk_i(clk), .reset_i(reset), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_last_i(in_last), .in_ready_o(mx_in_ready), .out_value_o(mx_value),
    .out_index_o(mx_index), .out_found_o(mx_found), .out_nan_o(mx_nan), .out_ovf_o(mx_ovf),
    .out_valid_o(mx_valid), .out_ready_i(out_ready)
  );

  float_argmax_stream #(.FIND_MIN(1'b1), .INDEX_WIDTH(16)) u_min (
    .clk_i(clk), .reset_i(reset), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_last_i(in_last), .in_ready_o(mn_in_ready), .out_value_o(mn_value),
    .out_index_o(mn_index), .out_found_o(mn_found), .out_nan_o(mn_nan), .out_ovf_o(mn_ovf),
    .out_valid_o(mn_valid), .out_ready_i(out_ready)
  );

  float_argmax_stream #(.FIND_MIN(1'b0), .INDEX_WIDTH(2)) u_ovf (
    .clk_i(clk), .reset_i(reset), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_last_i(in_last), .in_ready_o(ov_in_ready), .out_value_o(ov_value),
    .out_index_o(ov_index), .out_found_o(ov_found), .out_nan_o(ov_nan), .out_ovf_o(ov_ovf),
    .out_valid_o(ov_valid), .out_ready_i(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_data = 32'd0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_in_ready", {31'd0, mx_in_ready}, 32'd1);
    chk("rst_valid", {31'd0, mx_valid}, 32'd0);
    chk("rst_value", mx_value, 32'd0);
    chk("rst_index", {16'd0, mx_index}, 32'd0);
    chk("rst_flags", {29'd0, mx_found, mx_nan, mx_ovf}, 32'd0);

    // [1.0, 3.5, -2.0, 3.5]
    beat(32'h3F80_0000, 1'b0);
    beat(32'h4060_0000, 1'b0);
    beat(32'hC000_0000, 1'b0);
    chk("a_valid_early", {31'd0, mx_valid}, 32'd0);
    beat(32'h4060_0000, 1'b1);
    chk("a_valid", {31'd0, mx_valid}, 32'd1);
    chk("a_max_value", mx_value, 32'h4060_0000);
    chk("a_max_index", {16'd0, mx_index}, 32'd1);
    chk("a_max_flags", {29'd0, mx_found, mx_nan, mx_ovf}, 32'b100);
    chk("a_min_value", mn_value, 32'hC000_0000);
    chk("a_min_index", {16'd0, mn_index}, 32'd2);
    chk("a_ovf4_flag", {31'd0, ov_ovf}, 32'd0);
    chk("a_ovf4_index", {30'd0, ov_index}, 32'd1);

    // Backpressure with a beat offered during DONE that must be ignored.
    in_data = 32'h7F7F_FFFF; in_valid = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", {31'd0, mx_in_ready}, 32'd0);
      chk("bp_valid", {31'd0, mx_valid}, 32'd1);
      chk("bp_value", mx_value, 32'h4060_0000);
      chk("bp_index", {16'd0, mx_index}, 32'd1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    consume();
    chk("bp_release_ready", {31'd0, mx_in_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, mx_valid}, 32'd0);

    // [+0.0, -0.0, 5.0]
    beat(32'h0000_0000, 1'b0);
    beat(32'h8000_0000, 1'b0);
    beat(32'h40A0_0000, 1'b1);
    chk("z_min_value", mn_value, 32'h8000_0000);
    chk("z_min_index", {16'd0, mn_index}, 32'd1);
    chk("z_max_value", mx_value, 32'h40A0_0000);
    chk("z_max_index", {16'd0, mx_index}, 32'd2);
    consume();

    // [NaN, -inf, NaN]
    beat(32'h7FC0_0000, 1'b0);
    beat(32'hFF80_0000, 1'b0);
    beat(32'h7FC0_0000, 1'b1);
    chk("n_value", mx_value, 32'hFF80_0000);
    chk("n_index", {16'd0, mx_index}, 32'd1);
    chk("n_flags", {29'd0, mx_found, mx_nan, mx_ovf}, 32'b110);
    consume();

    // All-NaN single element
    beat(32'h7FC0_0001, 1'b1);
    chk("an_valid", {31'd0, mx_valid}, 32'd1);
    chk("an_value", mx_value, 32'h7FC0_0000);
    chk("an_index", {16'd0, mx_index}, 32'd0);
    chk("an_flags", {29'd0, mx_found, mx_nan, mx_ovf}, 32'b010);
    consume();

    // Single element [2.0]
    beat(32'h4000_0000, 1'b1);
    chk("s_value", mx_value, 32'h4000_0000);
    chk("s_index", {16'd0, mx_index}, 32'd0);
    chk("s_flags", {29'd0, mx_found, mx_nan, mx_ovf}, 32'b100);
    consume();

    // Ascending 1.0..6.0 with an in_valid gap; 2-bit index saturates.
    beat(32'h3F80_0000, 1'b0);
    beat(32'h4000_0000, 1'b0);
    tick(); tick();
    chk("g_hold_valid", {31'd0, mx_valid}, 32'd0);
    beat(32'h4040_0000, 1'b0);
    beat(32'h4080_0000, 1'b0);
    beat(32'h40A0_0000, 1'b0);
    beat(32'h40C0_0000, 1'b1);
    chk("o_value", ov_value, 32'h40C0_0000);
    chk("o_index", {30'd0, ov_index}, 32'd3);
    chk("o_ovf", {31'd0, ov_ovf}, 32'd1);
    chk("o_wide_index", {16'd0, mx_index}, 32'd5);
    chk("o_wide_ovf", {31'd0, mx_ovf}, 32'd0);
    consume();

    // Reset after 2 beats of a 4-beat vector.
    beat(32'h7F00_0000, 1'b0);
    beat(32'h7FC0_0000, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r_in_ready", {31'd0, mx_in_ready}, 32'd1);
    chk("r_value", mx_value, 32'd0);
    chk("r_flags", {29'd0, mx_found, mx_nan, mx_ovf}, 32'd0);
    beat(32'h40E0_0000, 1'b1);
    chk("r_new_value", mx_value, 32'h40E0_0000);
    chk("r_new_index", {16'd0, mx_index}, 32'd0);
    chk("r_new_flags", {29'd0, mx_found, mx_nan, mx_ovf}, 32'b100);

    // Reset while holding a result in DONE.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rd_valid", {31'd0, mx_valid}, 32'd0);
    chk("rd_in_ready", {31'd0, mx_in_ready}, 32'd1);
    chk("rd_value", mx_value, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
